// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding, bus widths, command/response
// bundles and the wait-counter sizing helper.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic                  err;
        logic [APB_DATA_W-1:0] rdata;
    } apb_rsp_t;

    // clog2(timeout+1), never narrower than one bit
    function automatic int wait_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus signals of the APB requester.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter with clear, enable and timeout compare.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = wait_cnt_w(TIMEOUT);
    localparam int unsigned LASTI = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [W-1:0] LAST = W'(LASTI);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // fires on the edge that would make the count reach TIMEOUT
    assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns a single-cycle response pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prst,
    apb_master_if.master bus
);

    apb_state_e        r_state, w_state_nx;
    logic              r_psel, w_psel_nx;
    logic              r_penable, w_penable_nx;
    logic              r_pwrite, w_pwrite_nx;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nx;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nx;
    logic              r_rsp_valid, w_rsp_valid_nx;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nx;
    logic              r_rsp_err, w_rsp_err_nx;

    logic w_accept;
    logic w_setup;
    logic w_wait;
    logic w_expire;

    assign bus.cmd_ready = (r_state == ST_IDLE) ||
                           ((r_state == ST_ACCESS) && bus.pready);
    assign w_accept = bus.cmd_valid && bus.cmd_ready;
    assign w_setup  = (r_state == ST_SETUP);
    assign w_wait   = (r_state == ST_ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (pclk),
        .i_rst    (prst),
        .i_clr    (w_setup),
        .i_en     (w_wait),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_psel_nx      = r_psel;
        w_penable_nx   = r_penable;
        w_pwrite_nx    = r_pwrite;
        w_paddr_nx     = r_paddr;
        w_pwdata_nx    = r_pwdata;
        w_rsp_valid_nx = 1'b0;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_rsp_err_nx   = r_rsp_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_pwrite_nx  = bus.cmd_write;
                    w_paddr_nx   = bus.cmd_addr;
                    w_pwdata_nx  = bus.cmd_wdata;
                    w_psel_nx    = 1'b1;
                    w_penable_nx = 1'b0;
                    w_state_nx   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable_nx = 1'b1;
                w_state_nx   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = r_pwrite ? '0 : bus.prdata;
                    w_rsp_err_nx   = 1'b0;
                    w_penable_nx   = 1'b0;
                    // back-to-back: next command goes straight to SETUP
                    if (w_accept) begin
                        w_pwrite_nx = bus.cmd_write;
                        w_paddr_nx  = bus.cmd_addr;
                        w_pwdata_nx = bus.cmd_wdata;
                        w_state_nx  = ST_SETUP;
                    end else begin
                        w_psel_nx  = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_expire) begin
                    w_psel_nx      = 1'b0;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = '0;
                    w_rsp_err_nx   = 1'b1;
                    w_state_nx     = ST_IDLE;
                end
            end
            default: begin
                w_psel_nx    = 1'b0;
                w_penable_nx = 1'b0;
                w_state_nx   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_psel      <= w_psel_nx;
            r_penable   <= w_penable_nx;
            r_pwrite    <= w_pwrite_nx;
            r_paddr     <= w_paddr_nx;
            r_pwdata    <= w_pwdata_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_rsp_err   <= w_rsp_err_nx;
        end
    end

    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers against a memory
// completer with programmable wait states, checked by a transaction model.
module tb_apb_master
    import apb_pkg::*;
;

    localparam int TO_A = 4;
    localparam int B_WAITS = 40;

    typedef struct {
        int       acc;
        int       due;
        apb_cmd_t cmd;
        apb_rsp_t rsp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    apb_master_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
    apb_master_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO_A)) u_a (
        .pclk (clk),
        .prst (rst),
        .bus  (ifa.master)
    );

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) u_b (
        .pclk (clk),
        .prst (rst),
        .bus  (ifb.master)
    );

    always #5 clk = ~clk;

    logic [7:0] smem [0:255] = '{default: 8'h00};
    int unsigned acc_a = 0;
    int unsigned acc_b = 0;
    int unsigned cur_wait = 0;

    assign ifa.pready = ifa.psel && ifa.penable && (acc_a >= cur_wait);
    assign ifa.prdata = smem[ifa.paddr];
    assign ifb.pready = ifb.psel && ifb.penable && (acc_b >= B_WAITS);
    assign ifb.prdata = 8'h3C;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_a <= 0;
        end else begin
            if (ifa.psel && ifa.penable && !ifa.pready) acc_a <= acc_a + 1;
            else acc_a <= 0;
            if (ifa.psel && ifa.penable && ifa.pready && ifa.pwrite)
                smem[ifa.paddr] <= ifa.pwdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) acc_b <= 0;
        else if (ifb.psel && ifb.penable && !ifb.pready) acc_b <= acc_b + 1;
        else acc_b <= 0;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit took = 0;
    int nxt_wait = 0;
    exp_t q[$];
    logic [7:0] mdl_mem [0:255];
    apb_rsp_t last = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        apb_rsp_t now;
        now = '{err: ifa.rsp_err, rdata: ifa.rsp_rdata};
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rsp_valid", ifa.rsp_valid, 1);
            chk("rsp_err", now.err, q[0].rsp.err);
            chk("rsp_rdata", now.rdata, q[0].rsp.rdata);
            last = q[0].rsp;
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", ifa.rsp_valid, 0);
            chk("rsp_hold", now, last);
        end
        chk("psel", ifa.psel, q.size() != 0);
        if (q.size() != 0) begin
            chk("penable", ifa.penable, cyc != q[0].acc + 1);
            chk("paddr", ifa.paddr, q[0].cmd.addr);
            chk("pwrite", ifa.pwrite, q[0].cmd.write);
            chk("pwdata", ifa.pwdata, q[0].cmd.wdata);
            chk("cmd_ready", ifa.cmd_ready,
                !q[0].rsp.err && (cyc == q[0].due - 1));
        end else begin
            chk("penable_idle", ifa.penable, 0);
            chk("cmd_ready_idle", ifa.cmd_ready, 1);
        end
    endtask

    // transaction-level expectation: phases and data from the bus rules
    task automatic model_accept(input apb_cmd_t c, input int waits);
        exp_t e;
        int access;
        e.acc = cyc;
        e.cmd = c;
        e.rsp.err = (TO_A != 0) && (waits >= TO_A);
        access = e.rsp.err ? TO_A : waits + 1;
        e.due = cyc + 2 + access;
        e.rsp.rdata = (!c.write && !e.rsp.err) ? mdl_mem[c.addr] : 8'h00;
        if (c.write && !e.rsp.err) mdl_mem[c.addr] = c.wdata;
        q.push_back(e);
    endtask

    task automatic step();
        check_outputs();
        took = ifa.cmd_valid && ifa.cmd_ready;
        if (took)
            model_accept('{write: ifa.cmd_write, addr: ifa.cmd_addr,
                           wdata: ifa.cmd_wdata}, nxt_wait);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic w, input logic [7:0] a,
                        input logic [7:0] d, input int waits);
        int guard;
        guard = 0;
        ifa.cmd_valid = 1'b1;
        ifa.cmd_write = w;
        ifa.cmd_addr  = a;
        ifa.cmd_wdata = d;
        nxt_wait = waits;
        do begin
            step();
            guard++;
        end while (!took && guard < 100);
        chk("accept", took, 1);
        ifa.cmd_valid = 1'b0;
        cur_wait = waits;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        step();
    endtask

    initial begin
        int n;
        int drops;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        ifa.cmd_valid = 0; ifa.cmd_write = 0;
        ifa.cmd_addr = 0;  ifa.cmd_wdata = 0;
        ifb.cmd_valid = 0; ifb.cmd_write = 0;
        ifb.cmd_addr = 0;  ifb.cmd_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", ifa.psel, 0);
        chk("rst_penable", ifa.penable, 0);
        chk("rst_pwrite", ifa.pwrite, 0);
        chk("rst_paddr", ifa.paddr, 0);
        chk("rst_pwdata", ifa.pwdata, 0);
        chk("rst_rsp", {ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata}, 0);
        chk("rst_ready", ifa.cmd_ready, 1);
        chk("rst_b_psel", ifb.psel, 0);
        rst = 1'b0;
        cyc = 0;
        repeat (2) step();

        send(1'b1, 8'h03, 8'hA5, 0);
        drain();
        send(1'b0, 8'h03, 8'h00, 0);
        drain();

        send(1'b1, 8'h01, 8'h11, 0);
        send(1'b1, 8'h02, 8'h22, 0);
        drain();

        send(1'b1, 8'h05, 8'h5C, 0);
        drain();
        send(1'b0, 8'h05, 8'h77, 3);
        drain();

        send(1'b0, 8'h07, 8'h00, 20);
        drain();

        send(1'b0, 8'h05, 8'h00, 3);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_psel", ifa.psel, 0);
        chk("arst_penable", ifa.penable, 0);
        chk("arst_rsp_valid", ifa.rsp_valid, 0);
        q.delete();
        last = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        repeat (6) step();
        send(1'b0, 8'h05, 8'h00, 0);
        drain();

        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            send($urandom_range(0, 1), 8'($urandom_range(0, 15)),
                 8'($urandom), $urandom_range(0, 5));
            repeat (gap) step();
        end
        drain();
        for (int a = 0; a < 4; a++) begin
            send(1'b0, 8'(a), 8'h00, 0);
        end
        drain();

        ifb.cmd_valid = 1'b1;
        ifb.cmd_write = 1'b0;
        ifb.cmd_addr  = 8'h09;
        chk("b_ready", ifb.cmd_ready, 1);
        @(posedge clk);
        #1;
        ifb.cmd_valid = 1'b0;
        n = 1;
        drops = 0;
        while (!ifb.rsp_valid && n < 200) begin
            if (!ifb.psel) drops++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("b_latency", n, 3 + B_WAITS);
        chk("b_psel_held", drops, 0);
        chk("b_rsp_err", ifb.rsp_err, 0);
        chk("b_rsp_rdata", ifb.rsp_rdata, 8'h3C);
        @(posedge clk);
        #1;
        chk("b_idle", {ifb.psel, ifb.rsp_valid, ifb.cmd_ready}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) for the team's 8-bit APB bus: turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns read data or completion status.
- Sits between a local controller (CPU shim, test sequencer) and one or more APB completers; drives the same pwrite/penable/psel/paddr/pwdata and samples the same prdata/pready as the team's APB slave.
- One transfer in flight at a time; back-to-back transfers supported with no idle cycle between them.

Parameters:
- ADDR_W, 8, paddr and cmd_addr width.
- DATA_W, 8, pwdata/prdata/cmd_wdata/rsp_rdata width.
- TIMEOUT, 16, consecutive ACCESS cycles with pready low before the transfer is aborted; 0 disables the timeout.

Ports:
- pclk  in  1  bus clock; all logic on its rising edge.
- prst  in  1  reset; asynchronous assert, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 on writes and on timeout.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB completer ready.

Behaviour:
- All outputs are registered except cmd_ready, which is decoded from state and pready.
- Reset (prst high, asynchronous):
  - state IDLE.
  - psel = penable = pwrite = 0; paddr = pwdata = 0.
  - rsp_valid = rsp_err = 0; rsp_rdata = 0; wait counter = 0.
  - Reset mid-transfer drops psel/penable immediately; the transfer is lost and no response is issued.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, psel = 1, penable = 0, go to SETUP.
- SETUP:
  - cmd_ready = 0.
  - Exactly one cycle; next edge sets penable = 1, clears the wait counter, goes to ACCESS.
- ACCESS with pready = 1 (completion edge):
  - rsp_valid = 1 next cycle.
  - rsp_rdata = prdata if read, else 0; rsp_err = 0.
  - penable = 0.
  - cmd_ready = 1 during this cycle. If a command is accepted on the same edge: load the new command, keep psel = 1, go to SETUP (back-to-back, no IDLE cycle). Otherwise psel = 0, go to IDLE.
- ACCESS with pready = 0:
  - cmd_ready = 0; paddr/pwrite/pwdata/psel/penable held stable.
  - Wait counter increments.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT, abort: psel = penable = 0, rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0, go to IDLE.
  - No command is accepted on the abort edge.
- Latency:
  - Accept edge to first SETUP cycle: 1.
  - Minimum accept-to-rsp_valid: 3 cycles (SETUP, ACCESS, response).
  - Each wait state adds 1 cycle.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err hold their value until the next response.
- pwdata is driven with the latched value on reads as well; completers ignore it.
- Wait counter width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2).
  - APB_ADDR_W = 8, APB_DATA_W = 8.
  - Command/response field widths, shared with the APB slave and the bench.
- Sub-module apb_wait_timer: the saturating wait counter with clear, enable and timeout compare. Everything else stays in apb_master.

Test Plan:
- Write then read, against the team slave (pready tied 1): write 0x03 <- 0xA5, then read 0x03 -> rsp_rdata = 0xA5, rsp_err = 0; each response 3 cycles after its accept edge.
- Back-to-back: cmd_valid held high for writes 0x01 <- 0x11 and 0x02 <- 0x22 -> psel stays high across both; second SETUP directly follows first ACCESS; two rsp_valid pulses 2 cycles apart.
- Wait states: completer holds pready low 3 cycles on read 0x05 returning 0x5C -> penable high 4 cycles, paddr stable throughout, rsp_rdata = 0x5C 6 cycles after accept.
- Timeout (TIMEOUT = 4): pready held 0 -> abort after 4 ACCESS cycles; rsp_valid with rsp_err = 1, rsp_rdata = 0; psel = 0; cmd_ready = 1 the following cycle.
- Reset mid-ACCESS: prst asserted asynchronously between clock edges -> psel/penable/rsp_valid = 0 immediately; no response after release; the next command completes normally.
- TIMEOUT = 0 with 40 wait cycles -> no abort; completes with rsp_err = 0.
